// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared types, reset defaults and helpers for seq_detector_param.
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Control FSM: RUN is normal operation; FLUSH follows every cfg_load.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  // Power-on pattern (right-aligned) and length: the legacy "0110" detector.
  localparam int unsigned DEF_PATTERN = 32'b0110;
  localparam int          DEF_LEN     = 4;

  // A pattern length is usable only when it lies in 1..max.
  function automatic logic len_legal(input int len, input int max);
    return (len >= 1) && (len <= max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_sat_cnt
// Brief    : Saturating up-counter; a clear wins over a simultaneous increment.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count up to all-ones and hold there; clear has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Runtime-programmable serial pattern detector (1..MAX_LEN bits),
//            overlap/non-overlap selectable, registered match pulse and
//            saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
  parameter int                 DEF_LEN     = seq_det_pkg::DEF_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  import seq_det_pkg::*;

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  ctrl_state_t        state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q, hist_base, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_base, fill_d;
  logic               match;
  logic               z_q;
  logic               err_q;
  logic [MAX_LEN-1:0] len_mask;
  logic               load_ok;

  // Only the low len bits of history and pattern take part in the compare.
  assign len_mask = ~({MAX_LEN{1'b1}} << len_q);
  assign load_ok  = len_legal(int'(cfg_len), MAX_LEN);

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state, shifter/fill next values and the match decision.
  always_comb begin
    state_d   = state_q;
    hist_base = hist_q;
    fill_base = fill_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match     = 1'b0;

    case (state_q)
      RUN:     if (cfg_load) state_d = FLUSH;
      FLUSH: begin
        // History is discarded here; a bit arriving now starts a fresh window.
        hist_base = '0;
        fill_base = '0;
        state_d   = cfg_load ? FLUSH : RUN;
      end
      default: state_d = RUN;
    endcase

    if (cfg_load) begin
      // Load wins over a same-cycle data bit.
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid) begin
      hist_d = {hist_base[MAX_LEN-2:0], x};
      fill_d = (fill_base >= FILL_MAX) ? FILL_MAX : fill_base + LEN_W'(1);
      match  = (fill_d >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
      // Non-overlap: the next match must be built from len fresh bits.
      if (match && !ovl_q) fill_d = '0;
    end else begin
      hist_d = hist_base;
      fill_d = fill_base;
    end
  end

  // Datapath, configuration and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      err_q  <= 1'b0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= 1'b1;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= match;
      if (cfg_load) begin
        if (load_ok) begin
          pat_q <= cfg_pattern;
          len_q <= cfg_len;
          ovl_q <= cfg_overlap;
          err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign z       = z_q;
  assign cfg_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Brief    : Directed self-checking bench for seq_detector_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       z, z2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic       cfg_err, cfg_err2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic v);
    x       = b;
    x_valid = v;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
  endtask

  task automatic do_clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if (z !== 1'b0) $display("FAIL reset_z: got %b want 0", z); else pass_cnt++;
    total_cnt++;
    if (match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", match_count); else pass_cnt++;
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL reset_err: got %b want 0", cfg_err); else pass_cnt++;
  endtask

  task automatic test_default_overlap();
    logic [6:0] bits = 7'b0110110;
    logic [6:0] expz = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      drive_bit(bits[i], 1'b1);
      total_cnt++;
      if (z !== expz[i]) $display("FAIL default_z bit%0d: got %b want %b", 7 - i, z, expz[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (match_count !== 8'd2) $display("FAIL default_count: got %0d want 2", match_count);
    else pass_cnt++;
  endtask

  task automatic test_overlap_mode(input logic ovl);
    logic [4:0] bits = 5'b10101;
    logic [4:0] expz;
    logic [7:0] expc;
    expz = ovl ? 5'b00101 : 5'b00100;
    expc = ovl ? 8'd2 : 8'd1;
    do_load(8'b101, 4'd3, ovl);
    do_clr();
    for (int i = 4; i >= 0; i--) begin
      drive_bit(bits[i], 1'b1);
      total_cnt++;
      if (z !== expz[i]) $display("FAIL ovl%0b_z bit%0d: got %b want %b", ovl, 5 - i, z, expz[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (match_count !== expc) $display("FAIL ovl%0b_count: got %0d want %0d", ovl, match_count, expc);
    else pass_cnt++;
  endtask

  task automatic test_cfg_err();
    logic [2:0] bits = 3'b101;
    logic [2:0] expz = 3'b001;
    do_load(8'b0110, 4'd0, 1'b0);
    total_cnt++;
    if (cfg_err !== 1'b1) $display("FAIL err_len0: got %b want 1", cfg_err); else pass_cnt++;
    do_load(8'b0110, 4'd9, 1'b0);
    total_cnt++;
    if (cfg_err !== 1'b1) $display("FAIL err_len9: got %b want 1", cfg_err); else pass_cnt++;
    for (int i = 2; i >= 0; i--) begin
      drive_bit(bits[i], 1'b1);
      total_cnt++;
      if (z !== expz[i]) $display("FAIL err_oldpat_z bit%0d: got %b want %b", 3 - i, z, expz[i]);
      else pass_cnt++;
    end
    do_load(8'b0110, 4'd4, 1'b1);
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL err_clear: got %b want 0", cfg_err); else pass_cnt++;
  endtask

  task automatic test_valid_gaps();
    logic [6:0] bits = 7'b0001110;
    logic [6:0] vld  = 7'b1001011;
    logic [6:0] expz = 7'b0000001;
    do_clr();
    for (int i = 6; i >= 0; i--) begin
      drive_bit(bits[i], vld[i]);
      total_cnt++;
      if (z !== expz[i]) $display("FAIL gap_z step%0d: got %b want %b", 7 - i, z, expz[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (match_count !== 8'd1) $display("FAIL gap_count: got %0d want 1", match_count);
    else pass_cnt++;
  endtask

  task automatic test_len_one();
    logic [3:0] bits = 4'b1101;
    logic [3:0] expz = 4'b1101;
    do_load(8'b1010_1011, 4'd1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      drive_bit(bits[i], 1'b1);
      total_cnt++;
      if (z !== expz[i]) $display("FAIL len1_z bit%0d: got %b want %b", 4 - i, z, expz[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    logic [15:0] bits = 16'b0110_1101_1011_0110;
    logic [15:0] expz = 16'b0001_0010_0100_1001;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      drive_bit(bits[i], 1'b1);
      total_cnt++;
      if (z2 !== expz[i]) $display("FAIL sat_z bit%0d: got %b want %b", 16 - i, z2, expz[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (match_count2 !== 2'd3) $display("FAIL sat_count2: got %0d want 3", match_count2);
    else pass_cnt++;
    total_cnt++;
    if (match_count !== 8'd5) $display("FAIL sat_count8: got %0d want 5", match_count);
    else pass_cnt++;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    cnt_clr = 1'b1;
    drive_bit(1'b0, 1'b1);
    cnt_clr = 1'b0;
    total_cnt++;
    if (z2 !== 1'b1) $display("FAIL clr_vs_match_z: got %b want 1", z2); else pass_cnt++;
    total_cnt++;
    if (match_count2 !== 2'd0) $display("FAIL clr_vs_match_count: got %0d want 0", match_count2);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [3:0] bits = 4'b0110;
    logic [3:0] expz = 4'b0001;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    reset   = 1'b1;
    x       = 1'b0;
    x_valid = 1'b1;
    tick();
    reset   = 1'b0;
    x_valid = 1'b0;
    total_cnt++;
    if (z !== 1'b0) $display("FAIL abort_after_reset_z: got %b want 0", z); else pass_cnt++;
    total_cnt++;
    if (match_count !== 8'd0) $display("FAIL abort_count: got %0d want 0", match_count); else pass_cnt++;
    drive_bit(1'b0, 1'b1);
    total_cnt++;
    if (z !== 1'b0) $display("FAIL abort_single0_z: got %b want 0", z); else pass_cnt++;
    for (int i = 3; i >= 0; i--) begin
      drive_bit(bits[i], 1'b1);
      total_cnt++;
      if (z !== expz[i]) $display("FAIL abort_full_z bit%0d: got %b want %b", 4 - i, z, expz[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_overlap_mode(1'b0);
    test_overlap_mode(1'b1);
    test_cfg_err();
    test_valid_gaps();
    test_len_one();
    test_saturation();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
